// File: rtl/bjp_stat_pkg.sv
// Shared definitions for the branch/jump prediction statistics block:
// class encodings, controller states and default widths.
package bjp_stat_pkg;

  localparam int unsigned BJP_CNT_W   = 32;
  localparam int unsigned BJP_NUM_CLS = 9;
  localparam int unsigned BJP_CLS_W   = 4;

  typedef enum logic [BJP_CLS_W-1:0] {
    BJP_CLS_BEQ  = 4'd0,
    BJP_CLS_BNE  = 4'd1,
    BJP_CLS_BLT  = 4'd2,
    BJP_CLS_BGE  = 4'd3,
    BJP_CLS_BLTU = 4'd4,
    BJP_CLS_BGEU = 4'd5,
    BJP_CLS_BEQZ = 4'd6,
    BJP_CLS_BNEZ = 4'd7,
    BJP_CLS_RET  = 4'd8
  } bjp_cls_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDump = 2'd1,
    StDone = 2'd2
  } bjp_state_e;

endpackage

// File: rtl/bjp_cnt_bank.sv
// Bank of per-class saturating total/miss counter pairs with one increment port,
// a synchronous clear and one combinational read port.
module bjp_cnt_bank
  import bjp_stat_pkg::*;
#(
  parameter int unsigned CNT_W   = BJP_CNT_W,
  parameter int unsigned NUM_CLS = BJP_NUM_CLS,
  parameter int unsigned CLS_W   = BJP_CLS_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic [CLS_W-1:0] i_cls,
  input  logic             i_inc_total,
  input  logic             i_inc_miss,
  input  logic [CLS_W-1:0] i_rd_cls,
  output logic [CNT_W-1:0] o_rd_total,
  output logic [CNT_W-1:0] o_rd_miss
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] r_total [NUM_CLS];
  logic [CNT_W-1:0] r_miss  [NUM_CLS];

  // Both counters saturate independently; since miss only moves with total,
  // miss <= total holds even once total has pinned at CntMax.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      for (int i = 0; i < NUM_CLS; i++) begin
        r_total[i] <= '0;
        r_miss[i]  <= '0;
      end
    end else if (i_inc_total) begin
      for (int i = 0; i < NUM_CLS; i++) begin
        if (i_cls == CLS_W'(i)) begin
          if (r_total[i] != CntMax) r_total[i] <= r_total[i] + CNT_W'(1);
          if (i_inc_miss && (r_miss[i] != CntMax)) r_miss[i] <= r_miss[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    o_rd_total = '0;
    o_rd_miss  = '0;
    for (int i = 0; i < NUM_CLS; i++) begin
      if (i_rd_cls == CLS_W'(i)) begin
        o_rd_total = r_total[i];
        o_rd_miss  = r_miss[i];
      end
    end
  end

endmodule

// File: rtl/bjp_stat_ctrl.sv
// Branch statistics controller: gates commit-point events into the counter bank,
// tracks dropped events and sequences the per-class valid/ready readout.
module bjp_stat_ctrl
  import bjp_stat_pkg::*;
#(
  parameter int unsigned CNT_W   = BJP_CNT_W,
  parameter int unsigned NUM_CLS = BJP_NUM_CLS,
  parameter int unsigned CLS_W   = BJP_CLS_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt_valid,
  input  logic [CLS_W-1:0] evt_cls,
  input  logic             evt_miss,
  input  logic             clr,
  input  logic             dump_start,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [CLS_W-1:0] dump_idx,
  output logic [CNT_W-1:0] dump_total,
  output logic [CNT_W-1:0] dump_miss,
  output logic             dump_done,
  output logic             busy,
  output logic             evt_drop
);

  localparam logic [CLS_W-1:0] LastIdx = CLS_W'(NUM_CLS - 1);

  bjp_state_e       r_state;
  logic [CLS_W-1:0] r_idx;
  logic             r_valid;
  logic             r_done;
  logic             r_busy;
  logic             r_drop;

  logic w_idle;
  logic w_cls_ok;
  logic w_clr;
  logic w_inc;
  logic w_drop;

  assign w_idle   = (r_state == StIdle);
  assign w_cls_ok = (32'(evt_cls) < NUM_CLS);
  assign w_clr    = clr && w_idle;
  // A same-cycle clear takes priority over the event.
  assign w_inc    = evt_valid && w_idle && w_cls_ok && !clr;
  assign w_drop   = evt_valid && (!w_idle || !w_cls_ok);

  bjp_cnt_bank #(
    .CNT_W  (CNT_W),
    .NUM_CLS(NUM_CLS),
    .CLS_W  (CLS_W)
  ) u_bank (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (w_clr),
    .i_cls      (evt_cls),
    .i_inc_total(w_inc),
    .i_inc_miss (w_inc && evt_miss),
    .i_rd_cls   (r_idx),
    .o_rd_total (dump_total),
    .o_rd_miss  (dump_miss)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_drop <= 1'b0;
      end else if (w_drop) begin
        r_drop <= 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (dump_start) begin
            r_state <= StDump;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
        StDump: begin
          if (dump_ready) begin
            if (r_idx == LastIdx) begin
              r_state <= StDone;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + CLS_W'(1);
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign dump_valid = r_valid;
  assign dump_idx   = r_idx;
  assign dump_done  = r_done;
  assign busy       = r_busy;
  assign evt_drop   = r_drop;

endmodule
